// File: rtl/bamse_irq_ctrl.sv
// bamse_irq_ctrl: edge-triggered, maskable, fixed-priority interrupt controller for PicoBlaze3 with EOI handshake.
// Revision: 1.0
`default_nettype none

module bamse_irq_ctrl #(
  parameter int unsigned NSRC      = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic [7:0]      port_id,
  input  logic            write_strobe,
  input  logic            read_strobe,
  input  logic [7:0]      out_port,
  output logic [7:0]      in_port,
  output logic            interrupt,
  input  logic            interrupt_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [7:0]      vect_q, vect_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] win;
  logic [2:0]      win_id;
  logic            take;
  logic [7:0]      off;
  logic            hit;
  logic            wr_pend, wr_mask, wr_eoi;
  logic            unused_inputs;

  // Reads have no side effects, so the read qualifier is not needed.
  assign unused_inputs = ^{read_strobe, out_port};

  assign rise    = irq_src & ~prev_q;
  assign act     = pend_q & mask_q;
  assign off     = port_id - BASE_ADDR;
  assign hit     = (off < 8'd4);
  assign wr_pend = write_strobe & hit & (off[1:0] == 2'd0);
  assign wr_mask = write_strobe & hit & (off[1:0] == 2'd1);
  assign wr_eoi  = write_strobe & hit & (off[1:0] == 2'd3);

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win    = '0;
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        win    = '0;
        win[i] = 1'b1;
        win_id = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vect_d  = vect_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|act) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (interrupt_ack) begin
          state_d = ST_SERVICE;
          if (|act) begin
            vect_d = {2'b10, 3'b000, win_id};
            take   = 1'b1;
          end else begin
            vect_d = 8'hC0;
          end
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          vect_d  = 8'h00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // New edges are OR-ed in last so they override both W1C and ack clears.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~out_port[NSRC-1:0];
    if (take)    pend_d = pend_d & ~win;
    pend_d = pend_d | rise;
    mask_d = wr_mask ? out_port[NSRC-1:0] : mask_q;
  end

  always_comb begin
    rdata_d = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0: for (int i = 0; i < NSRC; i++) rdata_d[i] = pend_q[i];
        2'd1: for (int i = 0; i < NSRC; i++) rdata_d[i] = mask_q[i];
        2'd2: rdata_d = vect_q;
        default: rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '1;
      pend_q  <= '0;
      mask_q  <= '0;
      vect_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_src;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vect_q  <= vect_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_port   = rdata_q;
  assign interrupt = (state_q == ST_ASSERT);

endmodule

`default_nettype wire
